// File: rtl/dc_miss_handler.sv
// Single-outstanding DC miss handler: issues the L2 request, picks an RRIP victim
// (aging the set when nothing is evictable), displaces it and writes the fill.
//
// state | meaning
// IDLE  | accepting a new miss
// REQ   | L2 request held until accepted
// SCAN  | reading ways 0..7, evaluating each one cycle after its read
// AGE   | rewriting all 8 captured ways with rrip+1, then rescanning
// DISP  | victim displacement held until accepted
// WAIT  | victim chosen, waiting for the L2 ack
// FILL  | writing the new tag entry
module dc_miss_handler #(
  parameter int Ways     = 8,
  parameter int Sets     = 32,
  parameter int FillRrip = 2,
  localparam int WayW    = $clog2(Ways),
  localparam int IdxW    = $clog2(Sets)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 miss_valid,
  output logic                 miss_retry,
  input  logic [IdxW-1:0]      miss_index,
  input  logic [9:0]           miss_tag,
  input  logic                 miss_write,
  output logic                 l1tol2_req_valid,
  input  logic                 l1tol2_req_retry,
  output logic [2:0]           l1tol2_req,
  input  logic                 l2tol1_snack_valid,
  input  logic [4:0]           l2tol1_snack,
  output logic                 l1tol2_disp_valid,
  input  logic                 l1tol2_disp_retry,
  output logic [2:0]           l1tol2_disp,
  output logic                 tb_rd_valid,
  output logic [IdxW+WayW-1:0] tb_rd_pos,
  input  logic [14:0]          tb_rd_data,
  output logic                 tb_wr_valid,
  output logic [IdxW+WayW-1:0] tb_wr_pos,
  output logic [14:0]          tb_wr_data,
  output logic                 fill_valid,
  output logic [WayW-1:0]      fill_way
);

  localparam logic [2:0] ST_I       = 3'b000;
  localparam logic [2:0] ST_S       = 3'b001;
  localparam logic [2:0] ST_M       = 3'b011;
  localparam logic [2:0] CMD_REQ_S  = 3'd1;
  localparam logic [2:0] CMD_REQ_M  = 3'd2;
  localparam logic [4:0] SCMD_ACK_S = 5'd4;
  localparam logic [4:0] SCMD_ACK_M = 5'd5;
  localparam logic [1:0] FILL_RRIP  = 2'(FillRrip);
  localparam logic [WayW-1:0] LAST_WAY = WayW'(Ways - 1);

  typedef enum logic [2:0] {IDLE, REQ, SCAN, AGE, DISP, WAIT, FILL} fsm_t;

  fsm_t            state, state_next;
  logic [IdxW-1:0] idx_q;
  logic [9:0]      tag_q;
  logic            write_q;
  logic [WayW:0]   rd_cnt;
  logic            eval_valid;
  logic [WayW-1:0] eval_way;
  logic [14:0]     entries [Ways];
  logic [WayW-1:0] victim;
  logic [2:0]      victim_state;
  logic [WayW-1:0] age_cnt;
  logic            ack_seen, ack_m;

  logic            ack_now, hit, scan_done;
  logic [2:0]      rd_state;
  logic [1:0]      rd_rrip;
  logic [14:0]     age_entry;

  always_comb begin
    rd_state  = tb_rd_data[14:12];
    rd_rrip   = tb_rd_data[11:10];
    ack_now   = (state != IDLE) && l2tol1_snack_valid &&
                ((l2tol1_snack == SCMD_ACK_S) || (l2tol1_snack == SCMD_ACK_M));
    hit       = (state == SCAN) && eval_valid && ((rd_state == ST_I) || (rd_rrip == 2'b11));
    scan_done = (state == SCAN) && eval_valid && (eval_way == LAST_WAY) && !hit;
    age_entry = entries[age_cnt];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (miss_valid) state_next = REQ;
      REQ:  if (!l1tol2_req_retry) state_next = SCAN;
      SCAN: begin
        if (hit)            state_next = (rd_state != ST_I) ? DISP : WAIT;
        else if (scan_done) state_next = AGE;
      end
      AGE:  if (age_cnt == LAST_WAY) state_next = SCAN;
      DISP: if (!l1tol2_disp_retry) state_next = WAIT;
      WAIT: if (ack_seen || ack_now) state_next = FILL;
      FILL: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q        <= '0;
      tag_q        <= '0;
      write_q      <= 1'b0;
      rd_cnt       <= '0;
      eval_valid   <= 1'b0;
      eval_way     <= '0;
      victim       <= '0;
      victim_state <= '0;
      age_cnt      <= '0;
      ack_seen     <= 1'b0;
      ack_m        <= 1'b0;
      for (int i = 0; i < Ways; i++) entries[i] <= '0;
    end else begin
      if (state == IDLE && miss_valid) begin
        idx_q   <= miss_index;
        tag_q   <= miss_tag;
        write_q <= miss_write;
      end
      // The read issued this cycle is evaluated next cycle against eval_way.
      eval_valid <= tb_rd_valid;
      eval_way   <= rd_cnt[WayW-1:0];
      rd_cnt     <= (state == SCAN && state_next == SCAN) ? rd_cnt + {{WayW{1'b0}}, tb_rd_valid}
                                                          : '0;
      if (state == SCAN && eval_valid) entries[eval_way] <= tb_rd_data;
      if (hit) begin
        victim       <= eval_way;
        victim_state <= rd_state;
      end
      age_cnt <= (state == AGE) ? age_cnt + 1'b1 : '0;
      if (state == FILL) begin
        ack_seen <= 1'b0;
        ack_m    <= 1'b0;
      end else if (ack_now) begin
        ack_seen <= 1'b1;
        ack_m    <= (l2tol1_snack == SCMD_ACK_M);
      end
    end
  end

  always_comb begin
    miss_retry        = (state != IDLE);
    l1tol2_req_valid  = 1'b0;
    l1tol2_req        = '0;
    l1tol2_disp_valid = 1'b0;
    l1tol2_disp       = '0;
    tb_rd_valid       = 1'b0;
    tb_rd_pos         = '0;
    tb_wr_valid       = 1'b0;
    tb_wr_pos         = '0;
    tb_wr_data        = '0;
    fill_valid        = 1'b0;
    fill_way          = '0;
    case (state)
      REQ: begin
        l1tol2_req_valid = 1'b1;
        l1tol2_req       = write_q ? CMD_REQ_M : CMD_REQ_S;
      end
      SCAN: begin
        // No further reads once a victim is found or all ways are issued.
        tb_rd_valid = !rd_cnt[WayW] && !hit;
        tb_rd_pos   = {idx_q, rd_cnt[WayW-1:0]};
      end
      AGE: begin
        tb_wr_valid = 1'b1;
        tb_wr_pos   = {idx_q, age_cnt};
        tb_wr_data  = {age_entry[14:12], age_entry[11:10] + 2'd1, age_entry[9:0]};
      end
      DISP: begin
        l1tol2_disp_valid = 1'b1;
        l1tol2_disp       = victim_state;
      end
      FILL: begin
        tb_wr_valid = 1'b1;
        tb_wr_pos   = {idx_q, victim};
        tb_wr_data  = {ack_m ? ST_M : ST_S, FILL_RRIP, tag_q};
        fill_valid  = 1'b1;
        fill_way    = victim;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dc_miss_handler.sv
// Directed bench for dc_miss_handler with a behavioural tag bank model.
module tb_dc_miss_handler;

  localparam logic [2:0] ST_I = 3'b000;
  localparam logic [2:0] ST_S = 3'b001;
  localparam logic [2:0] ST_M = 3'b011;
  localparam logic [2:0] CMD_S = 3'd1;
  localparam logic [2:0] CMD_M = 3'd2;
  localparam logic [4:0] ACK_S = 5'd4;
  localparam logic [4:0] ACK_M = 5'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss_valid, miss_retry, miss_write;
  logic [4:0]  miss_index;
  logic [9:0]  miss_tag;
  logic        req_valid, req_retry;
  logic [2:0]  req;
  logic        snack_valid;
  logic [4:0]  snack;
  logic        disp_valid, disp_retry;
  logic [2:0]  disp;
  logic        rd_valid, wr_valid, fill_valid;
  logic [7:0]  rd_pos, wr_pos;
  logic [14:0] rd_data, wr_data;
  logic [2:0]  fill_way;

  logic        clr, pl_we;
  logic [7:0]  pl_pos;
  logic [14:0] pl_data;
  logic [14:0] mem [256];
  int          wr_cnt = 0, overlap_cnt = 0;
  int          n_total = 0, n_pass = 0, n_fail = 0;

  always #5 clk = ~clk;

  dc_miss_handler dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_retry(miss_retry), .miss_index(miss_index),
    .miss_tag(miss_tag), .miss_write(miss_write),
    .l1tol2_req_valid(req_valid), .l1tol2_req_retry(req_retry), .l1tol2_req(req),
    .l2tol1_snack_valid(snack_valid), .l2tol1_snack(snack),
    .l1tol2_disp_valid(disp_valid), .l1tol2_disp_retry(disp_retry), .l1tol2_disp(disp),
    .tb_rd_valid(rd_valid), .tb_rd_pos(rd_pos), .tb_rd_data(rd_data),
    .tb_wr_valid(wr_valid), .tb_wr_pos(wr_pos), .tb_wr_data(wr_data),
    .fill_valid(fill_valid), .fill_way(fill_way)
  );

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      if (pl_we) mem[pl_pos] <= pl_data;
      if (wr_valid) mem[wr_pos] <= wr_data;
    end
    if (rd_valid) rd_data <= mem[rd_pos];
    if (wr_valid) wr_cnt <= wr_cnt + 1;
    if (rd_valid && wr_valid) overlap_cnt <= overlap_cnt + 1;
  end

  function automatic logic [14:0] ent(input logic [2:0] st, input logic [1:0] rr, input logic [9:0] tg);
    return {st, rr, tg};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] pos, input logic [14:0] data);
    pl_we = 1'b1; pl_pos = pos; pl_data = data;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Leaves the caller at the negedge of the first REQ cycle.
  task automatic start_miss(input logic [4:0] idx, input logic [9:0] tg, input logic wr);
    miss_valid = 1'b1; miss_index = idx; miss_tag = tg; miss_write = wr;
    @(negedge clk);
    miss_valid = 1'b0;
  endtask

  task automatic send_ack(input logic [4:0] code);
    snack_valid = 1'b1; snack = code;
    @(negedge clk);
    snack_valid = 1'b0; snack = '0;
  endtask

  task automatic wait_fill(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (fill_valid) break;
      @(negedge clk);
    end
    check(tag, fill_valid, 1);
  endtask

  task automatic check_fill(input string tag, input logic [7:0] pos, input logic [14:0] data,
                            input logic [2:0] way);
    check({tag, "_wr_valid"}, wr_valid, 1);
    check({tag, "_pos"}, wr_pos, pos);
    check({tag, "_data"}, wr_data, data);
    check({tag, "_way"}, fill_way, way);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_miss_retry"}, miss_retry, 0);
    check({tag, "_req_valid"}, req_valid, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_wr_valid"}, wr_valid, 0);
    check({tag, "_disp_valid"}, disp_valid, 0);
    check({tag, "_fill_valid"}, fill_valid, 0);
    check({tag, "_data_outs"}, {req, disp, wr_data, wr_pos, rd_pos}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, wr0, quiet;
    reset = 1'b1; clr = 1'b1; pl_we = 1'b0; pl_pos = '0; pl_data = '0;
    miss_valid = 1'b0; miss_index = '0; miss_tag = '0; miss_write = 1'b0;
    req_retry = 1'b0; snack_valid = 1'b0; snack = '0; disp_retry = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;
    @(negedge clk);

    // Load miss into an all-invalid set: way 0, no displacement.
    start_miss(5'd5, 10'h155, 1'b0);
    check("t1_req_valid", req_valid, 1);
    check("t1_req_cmd", req, CMD_S);
    check("t1_miss_retry", miss_retry, 1);
    @(negedge clk);
    check("t1_rd_valid", rd_valid, 1);
    check("t1_rd_pos", rd_pos, 8'd40);
    @(negedge clk);
    @(negedge clk);
    check("t1_no_disp", disp_valid, 0);
    send_ack(5'd9);
    quiet = 1;
    for (int i = 0; i < 3; i++) begin
      if (fill_valid) quiet = 0;
      @(negedge clk);
    end
    check("t1_bogus_snack_ignored", quiet, 1);
    send_ack(ACK_S);
    wait_fill("t1_fill_seen", 4);
    check_fill("t1", 8'd40, ent(ST_S, 2'd2, 10'h155), 3'd0);
    @(negedge clk);
    check("t1_idle_retry", miss_retry, 0);
    check("t1_fill_pulse", fill_valid, 0);

    // Store miss, victim way 3 (rrip 3) holding S, displacement back-pressured.
    for (int w = 0; w < 8; w++)
      preload(8'(24 + w), (w == 3) ? ent(ST_S, 2'd3, 10'h0AA) : ent(ST_S, 2'd1, 10'(10'h40 + w)));
    disp_retry = 1'b1;
    start_miss(5'd3, 10'h2F0, 1'b1);
    check("t2_req_cmd", req, CMD_M);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (disp_valid) begin
        cnt++;
        check("t2_disp_state", disp, ST_S);
        if (cnt == 3) disp_retry = 1'b0;
      end else if (cnt > 0) break;
      @(negedge clk);
    end
    check("t2_disp_cycles", cnt, 3);
    send_ack(ACK_M);
    wait_fill("t2_fill_seen", 4);
    check_fill("t2", 8'd27, ent(ST_M, 2'd2, 10'h2F0), 3'd3);

    // All-S rrip-1 set: two aging passes, then way 0. Ack arrives early, during REQ.
    for (int w = 0; w < 8; w++) preload(8'(w), ent(ST_S, 2'd1, 10'(10'h10 + w)));
    wr0 = wr_cnt;
    start_miss(5'd0, 10'h3C3, 1'b0);
    send_ack(ACK_S);
    wait_fill("t3_fill_seen", 100);
    check("t3_age_writes", wr_cnt - wr0, 16);
    check_fill("t3", 8'd0, ent(ST_S, 2'd2, 10'h3C3), 3'd0);
    @(negedge clk);
    check("t3_mem_way1", mem[1], ent(ST_S, 2'd3, 10'h11));
    check("t3_mem_way7", mem[7], ent(ST_S, 2'd3, 10'h17));

    // L2 request back-pressure for 4 cycles.
    req_retry = 1'b1;
    start_miss(5'd7, 10'h001, 1'b1);
    quiet = 1;
    for (int k = 1; k <= 5; k++) begin
      if (!(req_valid && req == CMD_M && miss_retry)) quiet = 0;
      if (k == 5) req_retry = 1'b0;
      @(negedge clk);
    end
    check("t4_req_held_5", quiet, 1);
    check("t4_req_released", req_valid, 0);
    check("t4_busy", miss_retry, 1);
    send_ack(ACK_M);
    wait_fill("t4_fill_seen", 8);
    check_fill("t4", 8'd56, ent(ST_M, 2'd2, 10'h001), 3'd0);

    // ACK_M arrives during SCAN; victim way 2 holds M.
    for (int w = 0; w < 8; w++)
      preload(8'(72 + w), (w == 2) ? ent(ST_M, 2'd3, 10'h111) : ent(ST_S, 2'd1, 10'(10'h20 + w)));
    start_miss(5'd9, 10'h0F0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (rd_valid) break;
      @(negedge clk);
    end
    check("t5_scan_started", rd_valid, 1);
    send_ack(ACK_M);
    for (int i = 0; i < 10; i++) begin
      if (disp_valid) break;
      @(negedge clk);
    end
    check("t5_disp_valid", disp_valid, 1);
    check("t5_disp_state", disp, ST_M);
    wait_fill("t5_fill_seen", 5);
    check_fill("t5", 8'd74, ent(ST_M, 2'd2, 10'h0F0), 3'd2);

    // Reset during AGE abandons the miss, including its pending ack.
    for (int w = 0; w < 8; w++) preload(8'(80 + w), ent(ST_S, 2'd1, 10'(10'h30 + w)));
    start_miss(5'd10, 10'h222, 1'b0);
    send_ack(ACK_S);
    for (int i = 0; i < 40; i++) begin
      if (wr_valid) break;
      @(negedge clk);
    end
    check("t6_age_started", wr_valid, 1);
    check("t6_age_pos", wr_pos, 8'd80);
    check("t6_age_data", wr_data, ent(ST_S, 2'd2, 10'h30));
    reset = 1'b1;
    @(negedge clk);
    check_quiet("t6_reset");
    reset = 1'b0;
    @(negedge clk);
    check("t6_way1_untouched", mem[81], ent(ST_S, 2'd1, 10'h31));
    start_miss(5'd5, 10'h0AB, 1'b0);
    wr0 = wr_cnt;
    quiet = 1;
    for (int i = 0; i < 12; i++) begin
      if (fill_valid) quiet = 0;
      @(negedge clk);
    end
    check("t6_no_stale_ack", quiet, 1);
    check("t6_no_writes", wr_cnt - wr0, 0);
    send_ack(ACK_S);
    wait_fill("t6_fill_seen", 4);
    check_fill("t6", 8'd41, ent(ST_S, 2'd2, 10'h0AB), 3'd1);
    @(negedge clk);

    check("rd_wr_overlap", overlap_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
